// File: rtl/bemf_scheduler_pkg.sv
// Shared definitions for the back-EMF measurement scheduler.
//
// Contents:
//   AXES, ADC_W, AXIS_W    - axis count, ADC sample width, axis index width
//   schedState_t           - scheduler FSM state encoding
//   nextEnabledAxis()      - round-robin priority search. The register
//                            front-end decoder uses it as well.
package bemf_scheduler_pkg;

    localparam int AXES   = 4;
    localparam int ADC_W  = 10;
    localparam int AXIS_W = $clog2(AXES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FLOAT,
        ST_START,
        ST_CONV,
        ST_RESTORE
    } schedState_t;

    // Finds the lowest enabled axis strictly after 'last', wrapping from the
    // top axis back to axis 0. The offset runs from 1 to AXES, so 'last'
    // itself is the final candidate: a mask holding only 'last' selects it
    // again. An empty mask returns 'last'.
    function automatic logic [AXIS_W-1:0] nextEnabledAxis(
        input logic [AXES-1:0]   mask,
        input logic [AXIS_W-1:0] last
    );
        logic [AXIS_W-1:0] idx;
        logic              found;
        nextEnabledAxis = last;
        found           = 1'b0;
        for (int i = 1; i <= AXES; i++) begin
            idx = last + AXIS_W'(i);
            if (!found && mask[idx]) begin
                nextEnabledAxis = idx;
                found           = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/bemf_rr_pick.sv
// Combinational round-robin axis selector.
//
// Ports:
//   mask     in  AXES    participating axes
//   last     in  AXIS_W  most recently measured axis
//   nextAxis out AXIS_W  next axis to measure
//   wrap     out 1       no enabled axis has an index above 'last',
//                        so 'last' closes the current sweep
module bemf_rr_pick
    import bemf_scheduler_pkg::*;
(
    input  logic [AXES-1:0]   mask,
    input  logic [AXIS_W-1:0] last,
    output logic [AXIS_W-1:0] nextAxis,
    output logic              wrap
);

    // Selects the next axis and flags whether 'last' is the top of the sweep.
    always_comb begin
        nextAxis = nextEnabledAxis(mask, last);
        wrap     = 1'b1;
        for (int i = 0; i < AXES; i++) begin
            if ((AXIS_W'(i) > last) && mask[i]) begin
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bemf_scheduler.sv
// Round-robin back-EMF measurement scheduler. The four motor axes share one
// BEMF ADC. Once per measurement period the scheduler floats one enabled
// axis. It waits the settle time, runs one conversion, re-drives the axis
// and publishes the sample.
//
// Ports:
//   Clk, Reset      system clock, synchronous active-high reset
//   Enable          scheduler run enable
//   AxisEnable      per-axis participation mask
//   SettleCycles    float time before the conversion starts
//   PeriodCycles    spacing between the starts of consecutive measurements
//   Active          per-axis drive enable (0 = floating for measurement)
//   AdcStart/Chan   one-cycle conversion request and its channel
//   AdcDone/Data    conversion-complete strobe and its result
//   SampleValid     one-cycle publish strobe; SampleAxis/Data held until
//                   the next publish
//   TimeoutErr      sticky, set when a conversion times out
//   IntStatus       sticky, set once per completed sweep
//   IntReset        clears both sticky flags; a set in the same cycle wins
module bemf_scheduler
    import bemf_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [AXES-1:0]   AxisEnable,
    input  logic [7:0]        SettleCycles,
    input  logic [15:0]       PeriodCycles,
    output logic [AXES-1:0]   Active,
    output logic              AdcStart,
    output logic [AXIS_W-1:0] AdcChan,
    input  logic              AdcDone,
    input  logic [ADC_W-1:0]  AdcData,
    output logic              SampleValid,
    output logic [AXIS_W-1:0] SampleAxis,
    output logic [ADC_W-1:0]  SampleData,
    output logic              TimeoutErr,
    output logic              IntStatus,
    input  logic              IntReset
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    schedState_t       state, nextState;
    logic [15:0]       periodCnt;
    logic [7:0]        settleCnt;
    logic [TO_W-1:0]   toCnt;
    logic [AXIS_W-1:0] axis, axisNext, pickNext;
    logic              pickWrap;
    logic              periodExpired, enterFloat, capture, timeout, sweepDone;

    // Searching from the current axis yields both the next axis and the
    // sweep-complete flag for the axis being restored.
    bemf_rr_pick uPick (
        .mask     (AxisEnable),
        .last     (axis),
        .nextAxis (pickNext),
        .wrap     (pickWrap)
    );

    // A count of 1 or less means the period elapses this cycle. The next
    // FLOAT therefore starts exactly PeriodCycles after the previous one. If
    // the count ran out during a long measurement, RESTORE goes straight to
    // FLOAT.
    always_comb begin
        nextState     = state;
        capture       = 1'b0;
        timeout       = 1'b0;
        periodExpired = (periodCnt <= 16'd1);
        if (!Enable) begin
            nextState = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (AxisEnable != '0) nextState = ST_WAIT;
                end
                ST_WAIT: begin
                    if (AxisEnable == '0)   nextState = ST_IDLE;
                    else if (periodExpired) nextState = ST_FLOAT;
                end
                ST_FLOAT: begin
                    if (!AxisEnable[axis])     nextState = ST_RESTORE;
                    else if (settleCnt == '0)  nextState = ST_START;
                end
                ST_START: begin
                    if (!AxisEnable[axis]) nextState = ST_RESTORE;
                    else                   nextState = ST_CONV;
                end
                ST_CONV: begin
                    if (!AxisEnable[axis]) begin
                        nextState = ST_RESTORE;
                    end else if (AdcDone) begin
                        nextState = ST_RESTORE;
                        capture   = 1'b1;
                    end else if (toCnt == TO_W'(TIMEOUT - 1)) begin
                        nextState = ST_RESTORE;
                        timeout   = 1'b1;
                    end
                end
                ST_RESTORE: begin
                    if ((AxisEnable != '0) && periodExpired) nextState = ST_FLOAT;
                    else                                     nextState = ST_WAIT;
                end
                default: nextState = ST_IDLE;
            endcase
        end
        enterFloat = (nextState == ST_FLOAT) && (state != ST_FLOAT);
        axisNext   = enterFloat ? pickNext : axis;
        sweepDone  = (state == ST_RESTORE) && AxisEnable[axis] && pickWrap;
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    // Axis register. It resets to the top axis, so the first pick is the
    // lowest enabled axis.
    always_ff @(posedge Clk) begin
        if (Reset) axis <= AXIS_W'(AXES - 1);
        else       axis <= axisNext;
    end

    // Period counter. It loads on leaving IDLE and on every FLOAT entry, and
    // otherwise runs down to zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            periodCnt <= '0;
        end else if (enterFloat || (state == ST_IDLE && nextState == ST_WAIT)) begin
            periodCnt <= PeriodCycles;
        end else if (periodCnt != '0) begin
            periodCnt <= periodCnt - 16'd1;
        end
    end

    // Settle and conversion-timeout counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            settleCnt <= '0;
            toCnt     <= '0;
        end else begin
            if (enterFloat)                               settleCnt <= SettleCycles;
            else if (state == ST_FLOAT && settleCnt != '0) settleCnt <= settleCnt - 8'd1;
            if (nextState == ST_CONV && state != ST_CONV)  toCnt <= '0;
            else if (state == ST_CONV && toCnt != TO_W'(TIMEOUT - 1))
                toCnt <= toCnt + TO_W'(1);
        end
    end

    // Registered outputs, derived from the next state so that they line up
    // with the state they describe.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Active      <= '1;
            AdcStart    <= 1'b0;
            AdcChan     <= '0;
            SampleValid <= 1'b0;
            SampleAxis  <= '0;
            SampleData  <= '0;
            TimeoutErr  <= 1'b0;
            IntStatus   <= 1'b0;
        end else begin
            if (nextState inside {ST_FLOAT, ST_START, ST_CONV})
                Active <= ~(AXES'(1) << axisNext);
            else
                Active <= '1;
            AdcStart    <= (nextState == ST_START);
            if (enterFloat) AdcChan <= pickNext;
            SampleValid <= capture;
            if (capture) begin
                SampleAxis <= axis;
                SampleData <= AdcData;
            end
            TimeoutErr <= timeout   | (TimeoutErr & ~IntReset);
            IntStatus  <= sweepDone | (IntStatus  & ~IntReset);
        end
    end

endmodule

// File: tb/tb_bemf_scheduler.sv
// Directed self-checking bench for bemf_scheduler. An ADC model answers
// each AdcStart after a programmable latency and returns {channel, 8'h5A}.
module tb_bemf_scheduler;

    logic        Clk, Reset, Enable, IntReset;
    logic [3:0]  AxisEnable;
    logic [7:0]  SettleCycles;
    logic [15:0] PeriodCycles;
    logic [3:0]  Active;
    logic        AdcStart, AdcDone, SampleValid, TimeoutErr, IntStatus;
    logic [1:0]  AdcChan, SampleAxis;
    logic [9:0]  AdcData, SampleData;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int svCount = 0;
    int twoLow = 0;
    int badFloat = 0;
    int adcLatency;
    int mdlCnt;
    logic [1:0] mdlChan;
    bit manualDone;
    bit maskWatch;

    bemf_scheduler dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Enable       (Enable),
        .AxisEnable   (AxisEnable),
        .SettleCycles (SettleCycles),
        .PeriodCycles (PeriodCycles),
        .Active       (Active),
        .AdcStart     (AdcStart),
        .AdcChan      (AdcChan),
        .AdcDone      (AdcDone),
        .AdcData      (AdcData),
        .SampleValid  (SampleValid),
        .SampleAxis   (SampleAxis),
        .SampleData   (SampleData),
        .TimeoutErr   (TimeoutErr),
        .IntStatus    (IntStatus),
        .IntReset     (IntReset)
    );

    // Clock, with a cycle counter that advances on each rising edge.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        forever begin
            @(posedge Clk);
            cycleCount++;
        end
    end

    // ADC model. It runs shortly after each rising edge, so AdcDone is
    // stable for a full cycle.
    initial begin
        AdcDone = 1'b0;
        AdcData = 10'h000;
        mdlCnt  = 0;
        mdlChan = 2'd0;
        forever begin
            @(posedge Clk);
            #2;
            AdcDone = 1'b0;
            AdcData = 10'h3FF;
            if (mdlCnt > 0) begin
                mdlCnt--;
                if (mdlCnt == 0) begin
                    AdcDone = 1'b1;
                    AdcData = {mdlChan, 8'h5A};
                end
            end
            if (AdcStart && adcLatency > 0) begin
                mdlCnt  = adcLatency;
                mdlChan = AdcChan;
            end
            if (manualDone) begin
                AdcDone = 1'b1;
                AdcData = 10'h0AA;
            end
        end
    end

    // Background monitors: two axes floating at once, a disabled axis
    // floating, and every published sample.
    initial begin
        forever begin
            @(posedge Clk);
            #3;
            if (!Reset) begin
                if ($countones(~Active) > 1) twoLow++;
                if (maskWatch && (!Active[0] || !Active[2])) badFloat++;
                if (SampleValid) svCount++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, observed, expected, cycleCount);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] mask,
                                 input logic [7:0] settle, input logic [15:0] period);
        Enable       = en;
        AxisEnable   = mask;
        SettleCycles = settle;
        PeriodCycles = period;
    endtask

    function automatic bit eventSeen(input int kind);
        case (kind)
            0:       return Active != 4'hF;
            1:       return AdcStart;
            2:       return SampleValid;
            default: return Active == 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] actMask(input int a);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << a);
    endfunction

    // Waits on falling edges for an event. An expired budget counts as a
    // failed comparison.
    task automatic waitEvent(input int kind, input int budget, output int whenSeen);
        whenSeen = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (eventSeen(kind)) begin
                whenSeen = cycleCount;
                return;
            end
        end
        checkOutput($sformatf("waitKind%0d", kind), 0, 1);
    endtask

    // Follows one full measurement and checks axis, timing and data.
    task automatic measureOne(input int expAxis, input int settle, input int prevMark,
                              input int expGap, output int tFall, output int tSv);
        int tStart;
        waitEvent(0, 2000, tFall);
        checkOutput($sformatf("fallAxis%0d", expAxis), Active, actMask(expAxis));
        if (expGap >= 0) checkOutput($sformatf("fallGap%0d", expAxis), tFall - prevMark, expGap);
        waitEvent(1, 300, tStart);
        checkOutput($sformatf("startDelay%0d", expAxis), tStart - tFall, settle + 1);
        checkOutput($sformatf("adcChan%0d", expAxis), AdcChan, expAxis);
        waitEvent(2, 300, tSv);
        checkOutput($sformatf("sampleDelay%0d", expAxis), tSv - tStart, 6);
        checkOutput($sformatf("sampleAxis%0d", expAxis), SampleAxis, expAxis);
        checkOutput($sformatf("sampleData%0d", expAxis), SampleData, {expAxis[1:0], 8'h5A});
        checkOutput($sformatf("restored%0d", expAxis), Active, 4'hF);
    endtask

    initial begin
        int tFall, tSv, tStart, tRest, prevFall, svBefore;
        Reset      = 1'b1;
        IntReset   = 1'b0;
        adcLatency = 5;
        manualDone = 1'b0;
        maskWatch  = 1'b0;
        applyStimulus(1'b0, 4'h0, 8'd0, 16'd0);
        repeat (3) @(negedge Clk);

        // Reset values
        checkOutput("rstActive", Active, 4'hF);
        checkOutput("rstAdcStart", AdcStart, 0);
        checkOutput("rstAdcChan", AdcChan, 0);
        checkOutput("rstSampleValid", SampleValid, 0);
        checkOutput("rstSampleAxis", SampleAxis, 0);
        checkOutput("rstSampleData", SampleData, 0);
        checkOutput("rstTimeoutErr", TimeoutErr, 0);
        checkOutput("rstIntStatus", IntStatus, 0);

        // All four axes measured in order, starts 20 cycles apart
        Reset = 1'b0;
        applyStimulus(1'b1, 4'hF, 8'd3, 16'd20);
        prevFall = 0;
        for (int k = 0; k < 5; k++) begin
            measureOne(k % 4, 3, prevFall, (k == 0) ? -1 : 20, tFall, tSv);
            prevFall = tFall;
            if (k < 3) checkOutput($sformatf("intClear%0d", k), IntStatus, 0);
            if (k == 3) begin
                checkOutput("intBeforeSet", IntStatus, 0);
                @(negedge Clk);
                checkOutput("intSweepSet", IntStatus, 1);
            end
        end

        // Only axes 1 and 3 participate
        applyStimulus(1'b1, 4'b1010, 8'd3, 16'd20);
        maskWatch = 1'b1;
        @(negedge Clk);
        IntReset = 1'b1;
        @(negedge Clk);
        IntReset = 1'b0;
        checkOutput("intCleared", IntStatus, 0);
        for (int j = 0; j < 4; j++) begin
            measureOne((j % 2 == 0) ? 1 : 3, 3, prevFall, 20, tFall, tSv);
            prevFall = tFall;
            if (j == 1) begin
                @(negedge Clk);
                checkOutput("intSetAxis3", IntStatus, 1);
                IntReset = 1'b1;
                @(negedge Clk);
                IntReset = 1'b0;
                checkOutput("intClearAgain", IntStatus, 0);
            end else if (j == 3) begin
                IntReset = 1'b1;
                @(negedge Clk);
                checkOutput("intSetWins", IntStatus, 1);
                @(negedge Clk);
                IntReset = 1'b0;
                checkOutput("intLaterClear", IntStatus, 0);
            end else begin
                @(negedge Clk);
                checkOutput($sformatf("intStaysClear%0d", j), IntStatus, 0);
            end
        end

        // Conversion timeout on axis 1; scheduling then resumes with axis 3
        adcLatency = 0;
        svBefore   = svCount;
        waitEvent(0, 100, tFall);
        checkOutput("toFallAxis", Active, actMask(1));
        checkOutput("toFallGap", tFall - prevFall, 20);
        waitEvent(1, 100, tStart);
        checkOutput("toErrBefore", TimeoutErr, 0);
        waitEvent(3, 1100, tRest);
        checkOutput("toRestoreDelay", tRest - tStart, 1024);
        checkOutput("toErrSet", TimeoutErr, 1);
        checkOutput("toNoSample", svCount, svBefore);
        adcLatency = 5;
        measureOne(3, 3, tRest, 1, tFall, tSv);
        prevFall = tFall;
        @(negedge Clk);
        IntReset = 1'b1;
        @(negedge Clk);
        IntReset = 1'b0;
        checkOutput("toErrCleared", TimeoutErr, 0);
        checkOutput("intClearedTo", IntStatus, 0);

        // Enable dropped during conversion; a late AdcDone is ignored
        adcLatency = 0;
        waitEvent(0, 100, tFall);
        checkOutput("enFallAxis", Active, actMask(1));
        checkOutput("enFallGap", tFall - prevFall, 20);
        waitEvent(1, 100, tStart);
        svBefore = svCount;
        @(negedge Clk);
        @(negedge Clk);
        Enable = 1'b0;
        @(negedge Clk);
        checkOutput("enDropActive", Active, 4'hF);
        checkOutput("enDropAdcStart", AdcStart, 0);
        manualDone = 1'b1;
        @(negedge Clk);
        manualDone = 1'b0;
        repeat (4) @(negedge Clk);
        checkOutput("enLateDoneNoSample", svCount, svBefore);
        checkOutput("enIdleActive", Active, 4'hF);

        // Period shorter than a measurement: back-to-back with no skipped axis
        maskWatch  = 1'b0;
        adcLatency = 5;
        applyStimulus(1'b1, 4'hF, 8'd0, 16'd1);
        measureOne(2, 0, 0, -1, tFall, tSv);
        for (int k = 0; k < 4; k++) begin
            measureOne((k + 3) % 4, 0, tSv, 1, tFall, tSv);
        end

        checkOutput("neverTwoLow", twoLow, 0);
        checkOutput("disabledNeverFloat", badFloat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
